// File: rtl/asphalt_pio_in_edge.sv
// ---------------------------------------------------------------------------
// asphalt_pio_in_edge
//   Parametrised Avalon-MM input PIO. Each raw input is passed through a
//   2-flop synchroniser and a per-bit debouncer. Debounced edges of the
//   selected polarity are latched in a write-1-to-clear capture register,
//   and a maskable level interrupt is raised toward the processor.
//
// Parameters
//   WIDTH      number of input bits (1..32)
//   DEBOUNCE   cycles a new value must hold before acceptance (0 = bypass)
//   EDGE_TYPE  0 = rising, 1 = falling, 2 = any edge captured
//   CNT_W      debounce counter width (DEBOUNCE < 2**CNT_W)
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select (word offset)
//                0 data (RO), 1 reserved (reads 0),
//                2 irqmask (RW), 3 edgecap (R/W1C)
//   read       read strobe (read data is produced every cycle regardless)
//   write      write strobe
//   writedata  write data
//   readdata   registered read data, valid 1 cycle after address
//   in_port    raw asynchronous inputs
//   irq        level interrupt request
// ---------------------------------------------------------------------------
module asphalt_pio_in_edge #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned EDGE_TYPE = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Synchroniser stages
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Debounced value and its one-cycle delayed copy for edge detection
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_d;

    // Software-visible registers
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_mask;
    logic             w_wr_edgecap;

    // The read strobe is not needed because readdata is refreshed every
    // cycle; upper writedata bits are ignored when WIDTH < 32.
    logic w_unused;
    assign w_unused = read ^ (^writedata);

    // -----------------------------------------------------------------------
    // 2-flop synchroniser
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Debouncer
    // -----------------------------------------------------------------------
    generate
        if (DEBOUNCE == 0) begin : g_deb_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_deb <= '0;
                end else begin
                    r_deb <= r_s2;
                end
            end
        end else begin : g_deb_count
            localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE - 1);

            logic [CNT_W-1:0] r_cnt [WIDTH];

            // A differing value must be seen for DEBOUNCE consecutive cycles;
            // any return to the accepted value restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_deb <= '0;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (r_s2[i] == r_deb[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == LP_CNT_LAST) begin
                            r_deb[i] <= r_s2[i];
                            r_cnt[i] <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Edge detection on the debounced value
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
    end

    // -----------------------------------------------------------------------
    // Register writes
    // -----------------------------------------------------------------------
    assign w_wr_mask    = write && (address == 2'd2);
    assign w_wr_edgecap = write && (address == 2'd3);
    assign w_clr        = w_wr_edgecap ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Set is applied after clear so a new edge is never lost to a
    // coincident W1C write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux: registered every cycle; a same-cycle write is therefore
    // observed only on the following read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            case (address)
                2'd0:    r_readdata <= 32'(r_deb);
                2'd1:    r_readdata <= '0;
                2'd2:    r_readdata <= 32'(r_mask);
                default: r_readdata <= 32'(r_edgecap);
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_mask);

endmodule
